// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the read master (and the planned write master).
// Contents: RRESP/BRESP codes, read-master FSM state type, default bus widths.
package axil_pkg;

    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StRsp,
        StDrainAr,
        StDrainR
    } rd_state_e;

endpackage

// File: rtl/axi_lite_master_read_if.sv
// AXI-Lite read-channel bundle (AR + R).
// master modport: drives arvalid/araddr/arprot/rready, receives arready/rvalid/rdata/rresp.
// slave modport:  the mirror image.
interface axi_lite_master_read_if
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W = AXIL_ADDR_W,
    parameter int unsigned DATA_W = AXIL_DATA_W
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output arvalid, araddr, arprot, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, arprot, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_timeout_counter.sv
// Transaction watchdog shared by the AXI-Lite masters.
// Ports: clk/rst (async active-high), enable (count this cycle), clear (restart from 0),
// expired (count reached TIMEOUT_CYCLES-1 while enabled). TIMEOUT_CYCLES = 0 never expires.
module axil_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

            logic [CntW-1:0] count_q;

            // Saturates at Last so a waiter that outlives one expiry still sees it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_q <= '0;
                end else if (clear) begin
                    count_q <= '0;
                end else if (enable && (count_q != Last)) begin
                    count_q <= count_q + 1'b1;
                end
            end

            assign expired = enable && (count_q == Last);
        end
    endgenerate
endmodule

// File: rtl/axi_lite_master_read.sv
// Single-outstanding AXI-Lite read master with a watchdog.
// Ports: M_AXIL_ACLK/M_AXIL_ARESET (async active-high); cmd_* local read command
// (valid/ready, byte address, prot); rsp_* response (valid/ready, data, RRESP, timeout flag);
// m_axil AXI-Lite AR/R channels (master modport).
// A timed-out transaction is still completed on the bus afterwards (DRAIN states) so the
// slave never sees a withdrawn address or an unconsumed R beat.
module axi_lite_master_read
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W         = AXIL_ADDR_W,
    parameter int unsigned DATA_W         = AXIL_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  M_AXIL_ACLK,
    input  logic                  M_AXIL_ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    axi_lite_master_read_if.master m_axil
);
    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [2:0]        arprot_q, arprot_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    // AR still owed to the bus after an AR-phase timeout.
    logic              ar_pend_q, ar_pend_d;
    logic              timer_clear;
    logic              timer_expired;

    axil_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (M_AXIL_ACLK),
        .rst    (M_AXIL_ARESET),
        .enable ((state_q == StAr) || (state_q == StR)),
        .clear  (timer_clear),
        .expired(timer_expired)
    );

    // Gated by reset so the port reads 0 while reset is held and 1 right after release.
    assign cmd_ready = (state_q == StIdle) && !M_AXIL_ARESET;

    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        arprot_d      = arprot_q;
        rsp_data_d    = rsp_data_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        ar_pend_d     = ar_pend_q;
        timer_clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    state_d     = StAr;
                    araddr_d    = {cmd_addr[ADDR_W-1:2], 2'b00};
                    arprot_d    = cmd_prot;
                    timer_clear = 1'b1;
                end
            end
            StAr: begin
                if (m_axil.arready) begin
                    state_d = StR;
                end else if (timer_expired) begin
                    state_d       = StRsp;
                    rsp_data_d    = '0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                    ar_pend_d     = 1'b1;
                end
            end
            StR: begin
                if (m_axil.rvalid) begin
                    state_d       = StRsp;
                    rsp_data_d    = m_axil.rdata;
                    rsp_resp_d    = m_axil.rresp;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired) begin
                    state_d       = StRsp;
                    rsp_data_d    = '0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                    ar_pend_d     = 1'b0;
                end
            end
            StRsp: begin
                // ARVALID stays up here after an AR timeout; the slave may accept meanwhile.
                if (ar_pend_q && m_axil.arready) begin
                    ar_pend_d = 1'b0;
                end
                if (rsp_ready) begin
                    if (!rsp_timeout_q) begin
                        state_d = StIdle;
                    end else if (ar_pend_d) begin
                        state_d = StDrainAr;
                    end else begin
                        state_d = StDrainR;
                    end
                end
            end
            StDrainAr: begin
                if (m_axil.arready) begin
                    state_d   = StDrainR;
                    ar_pend_d = 1'b0;
                end
            end
            StDrainR: begin
                if (m_axil.rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        arvalid_d   = (state_d == StAr) || (state_d == StDrainAr) ||
                      ((state_d == StRsp) && ar_pend_d);
        rready_d    = (state_d == StR) || (state_d == StDrainR);
        rsp_valid_d = (state_d == StRsp);
    end

    always_ff @(posedge M_AXIL_ACLK or posedge M_AXIL_ARESET) begin
        if (M_AXIL_ARESET) begin
            state_q       <= StIdle;
            araddr_q      <= '0;
            arprot_q      <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            ar_pend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            araddr_q      <= araddr_d;
            arprot_q      <= arprot_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            ar_pend_q     <= ar_pend_d;
        end
    end

    assign m_axil.arvalid = arvalid_q;
    assign m_axil.araddr  = araddr_q;
    assign m_axil.arprot  = arprot_q;
    assign m_axil.rready  = rready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_timeout    = rsp_timeout_q;
endmodule

// File: tb/tb_axi_lite_master_read.sv
// Directed + randomized bench for axi_lite_master_read with an in-bench slave and an
// arithmetic model of the outcome/latency of each read.
module tb_axi_lite_master_read;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    axi_lite_master_read_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_master_read #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .M_AXIL_ACLK  (clk),
        .M_AXIL_ARESET(rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_prot     (cmd_prot),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .m_axil       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " arvalid"}, 64'(bus.arvalid), 0);
        check({tag, " rready"}, 64'(bus.rready), 0);
        check({tag, " rsp_valid"}, 64'(rsp_valid), 0);
    endtask

    // One complete read. Slave raises ARREADY on the ar_d-th ARVALID cycle and RVALID on
    // the r_d-th RREADY cycle; local side holds rsp_ready low for rsp_d cycles.
    task automatic run_txn(input string name, input logic [31:0] addr, input logic [2:0] prot,
                           input int ar_d, input int r_d, input int rsp_d,
                           input logic [31:0] data, input logic [1:0] resp);
        int          j_exp, lat, cyc, ac, rc, wc;
        bit          to, from_ar;
        logic [31:0] exp_addr, exp_data;
        logic [1:0]  exp_resp;

        // Watchdog model: waiting cycles are numbered from the first ARVALID cycle; the
        // count saturates at T-1 and expiry loses to a coincident ARREADY/RVALID.
        exp_addr = {addr[31:2], 2'b00};
        from_ar  = (ar_d >= T);
        j_exp    = 0;
        if (from_ar) begin
            to  = 1'b1;
            lat = T;
        end else begin
            j_exp = (T - 2 - ar_d > 0) ? T - 2 - ar_d : 0;
            to    = (r_d > j_exp);
            lat   = ar_d + 1 + (to ? j_exp : r_d) + 1;
        end
        exp_data = to ? 32'h0 : data;
        exp_resp = to ? 2'b10 : resp;

        wc = 0;
        while (cmd_ready !== 1'b1 && wc < 20) begin
            @(posedge clk); #1;
            wc++;
        end
        check({name, " cmd_ready before cmd"}, 64'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_prot  = prot;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_prot  = 3'($urandom);
        check({name, " arvalid after cmd"}, 64'(bus.arvalid), 1);
        check({name, " arprot"}, 64'(bus.arprot), 64'(prot));
        check({name, " cmd_ready busy"}, 64'(cmd_ready), 0);

        cyc = 0; ac = 0; rc = 0;
        while (rsp_valid !== 1'b1 && cyc < 200) begin
            if (bus.arvalid === 1'b1) begin
                check({name, " araddr"}, 64'(bus.araddr), 64'(exp_addr));
                bus.arready = (ac == ar_d);
                ac++;
            end else begin
                bus.arready = 1'b0;
            end
            if (bus.rready === 1'b1) begin
                bus.rvalid = (rc == r_d);
                rc++;
            end else begin
                bus.rvalid = 1'b0;
            end
            bus.rdata = bus.rvalid ? data : $urandom;
            bus.rresp = bus.rvalid ? resp : 2'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;

        check({name, " rsp_valid"}, 64'(rsp_valid), 1);
        check({name, " latency"}, 64'(cyc), 64'(lat));
        check({name, " rsp_data"}, 64'(rsp_data), 64'(exp_data));
        check({name, " rsp_resp"}, 64'(rsp_resp), 64'(exp_resp));
        check({name, " rsp_timeout"}, 64'(rsp_timeout), 64'(to));

        for (int i = 0; i < rsp_d; i++) begin
            @(posedge clk); #1;
            check({name, " hold rsp_valid"}, 64'(rsp_valid), 1);
            check({name, " hold rsp_data"}, 64'(rsp_data), 64'(exp_data));
            check({name, " hold rsp_resp"}, 64'(rsp_resp), 64'(exp_resp));
            check({name, " hold cmd_ready"}, 64'(cmd_ready), 0);
            check({name, " hold arvalid"}, 64'(bus.arvalid), 64'(from_ar));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        if (to) begin
            // Slave finishes the abandoned transaction late; the R beat must be swallowed.
            cyc = 0; ac = 0; rc = 0;
            while (cmd_ready !== 1'b1 && cyc < 40) begin
                check({name, " drain rsp_valid"}, 64'(rsp_valid), 0);
                bus.arready = (bus.arvalid === 1'b1) && (ac == 2);
                if (bus.arvalid === 1'b1) ac++;
                bus.rvalid = (bus.rready === 1'b1) && (rc == 2);
                if (bus.rready === 1'b1) rc++;
                bus.rdata = $urandom;
                bus.rresp = 2'($urandom);
                @(posedge clk); #1;
                cyc++;
            end
            bus.arready = 1'b0;
            bus.rvalid  = 1'b0;
            check({name, " drain ar cycles"}, 64'(ac), from_ar ? 3 : 0);
            check({name, " drain r cycles"}, 64'(rc), 3);
        end
        check({name, " cmd_ready after rsp"}, 64'(cmd_ready), 1);
        check({name, " rsp_valid after rsp"}, 64'(rsp_valid), 0);
    endtask

    initial begin
        int ar_d, r_d;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_prot    = '0;
        rsp_ready   = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = '0;

        #3;
        check("reset cmd_ready", 64'(cmd_ready), 0);
        check_idle_outputs("reset");
        check("reset araddr", 64'(bus.araddr), 0);
        check("reset arprot", 64'(bus.arprot), 0);
        check("reset rsp_data", 64'(rsp_data), 0);
        check("reset rsp_resp", 64'(rsp_resp), 0);
        check("reset rsp_timeout", 64'(rsp_timeout), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset cmd_ready", 64'(cmd_ready), 1);

        run_txn("zero_wait", 32'h0000_1004, 3'b000, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
        run_txn("misaligned_stall", 32'h0000_0013, 3'b101, 5, 3, 0, 32'hCAFE_F00D, 2'b11);
        run_txn("backpressure", 32'h0000_2008, 3'b010, 1, 2, 10, 32'h1234_5678, 2'b01);
        run_txn("after_backpressure", 32'h0000_200C, 3'b001, 0, 0, 0, 32'h0BAD_CAFE, 2'b00);
        run_txn("r_timeout", 32'h0000_3000, 3'b000, 0, 1000, 2, 32'h5555_5555, 2'b00);
        run_txn("after_r_timeout", 32'h0000_3004, 3'b000, 0, 0, 0, 32'hA5A5_0001, 2'b00);
        run_txn("ar_timeout", 32'h0000_4000, 3'b111, 1000, 0, 3, 32'h7777_7777, 2'b00);
        run_txn("ar_coincide", 32'h0000_4004, 3'b000, T - 1, 0, 0, 32'h0000_ABCD, 2'b00);
        run_txn("ar_coincide_then_to", 32'h0000_4008, 3'b000, T - 1, 1, 0, 32'h1, 2'b00);
        run_txn("r_coincide", 32'h0000_5000, 3'b000, 2, T - 4, 0, 32'hFEED_FACE, 2'b10);
        run_txn("r_one_late", 32'h0000_5004, 3'b000, 2, T - 3, 0, 32'hFEED_FACE, 2'b00);

        for (int n = 0; n < 30; n++) begin
            ar_d = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 2, T + 2)
                                                : $urandom_range(0, 6);
            r_d  = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 20)
                                                : $urandom_range(0, 6);
            run_txn("random", $urandom, 3'($urandom), ar_d, r_d, $urandom_range(0, 3),
                    $urandom, 2'($urandom));
        end

        // Async reset while waiting for R.
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_6000;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && bus.rready !== 1'b1; i++) begin
            bus.arready = bus.arvalid;
            @(posedge clk); #1;
        end
        bus.arready = 1'b0;
        check("mid_r rready", 64'(bus.rready), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_r reset cmd_ready", 64'(cmd_ready), 0);
        check_idle_outputs("mid_r reset");
        check("mid_r reset araddr", 64'(bus.araddr), 0);
        check("mid_r reset rsp_data", 64'(rsp_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_r release cmd_ready", 64'(cmd_ready), 1);
        check_idle_outputs("mid_r release");
        run_txn("after_reset", 32'h0000_6010, 3'b011, 0, 1, 1, 32'h3141_5926, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
